lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Memory-stage load/store unit: consumes the memory-request fields the ID/EX→EX/MEM pipeline carries (write enable, read enable, access size, unsigned flag) plus the ALU-computed address and store data.
- Executes each request as one transaction on the word-wide data bus.
- Stalls the pipeline via o_busy while the transaction is outstanding.
- Returns aligned, sign- or zero-extended load data.

Parameters:
- ADDR_WIDTH, 32, data-bus byte-address width (equals $size(Data)).

Ports:
- i_clock  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_memRdEnable  in  1  load request
- i_memWrEnable  in  1  store request
- i_memAccess  in  DataAccess  Byte/Half/Word
- i_memUnsigned  in  1  zero-extend load when 1
- i_addr  in  ADDR_WIDTH  byte address
- i_wrData  in  32  store data, LSB-justified
- o_busy  out  1  stall upstream pipeline
- o_rdData  out  32  extended load result
- o_rdValid  out  1  o_rdData valid (1-cycle pulse)
- o_misaligned  out  1  alignment fault (1-cycle pulse)
- o_busAddr  out  ADDR_WIDTH  word address, bits [1:0]=0
- o_busRdEnable  out  1  bus read request
- o_busWrEnable  out  1  bus write request
- o_busByteEnable  out  4  byte lanes
- o_busWrData  out  32  lane-replicated store data
- i_busReady  in  1  bus completes the current request this cycle
- i_busRdData  in  32  read data, valid when i_busReady=1

Behaviour:
- Reset: i_reset=0 asynchronously forces state IDLE and all outputs to 0, including bus requests deasserting immediately. This holds even mid-transaction; the bus must tolerate an abandoned request.
- States:
  - IDLE: request = i_memRdEnable|i_memWrEnable.
    - If a request is present: o_busy=1 combinationally in the same cycle. Capture address, size, unsigned, data and direction.
    - Aligned request → ACCESS. Misaligned request → FAULT.
    - No request → stay in IDLE, o_busy=0.
  - ACCESS: bus outputs driven from captured registers. o_busRdEnable/o_busWrEnable held stable until i_busReady=1.
    - On ready: load data is extracted and registered. Next state DONE.
    - Any number of wait cycles is allowed.
  - DONE: o_busy=0, so the pipeline advances at the end of this cycle. Inputs are ignored this cycle because the old instruction is still presented. For loads, o_rdValid=1 and o_rdData is valid. Next state IDLE.
  - FAULT: o_misaligned=1, o_busy=0, no bus activity. Next state IDLE.
- Latency: request at cycle N, ready at cycle N+k (k≥1), DONE at N+k+1, IDLE at N+k+2.
- o_rdData holds its last value until the next load completes.
- Both enables set: treated as a store, so no o_rdValid.
- Misalignment rules: Half with addr[0]=1; Word with addr[1:0]≠0; Byte is never misaligned.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0]
  - Half: 4'b0011<<{addr[1],1'b0}
  - Word: 4'b1111
- Store data:
  - Byte: wrData[7:0] replicated ×4
  - Half: wrData[15:0] replicated ×2
  - Word: as-is
- Load extraction: lane = i_busRdData>>(8*addr[1:0]). Then take the low 8/16/32 bits and sign-extend unless unsigned (Word ignores the unsigned flag).
- A load issued directly after a store starts a fresh transaction; there is no combining.

Decomposition:
- Types package: reuse Data, DataAccess; add the LsuState enum (IDLE, ACCESS, DONE, FAULT) and the constant BYTE_LANES=4.
- One combinational sub-module, lsu_lane_align, computes byte enables, store replication, load extraction/extension and the misalignment flag. It is unit-testable in isolation.

Test Plan:
- LW addr 0x100, i_busReady=1 in the first ACCESS cycle, bus data 0xDEADBEEF:
  - o_busAddr=0x100, BE=1111.
  - o_rdData=0xDEADBEEF with o_rdValid at cycle N+2.
  - o_busy high for cycles N..N+1 only.
- LB addr 0x203, bus data 0x80112233:
  - BE=1000, o_rdData=0xFFFFFF80.
  - Repeat as LBU → 0x00000080.
- LHU addr 0x302, bus data 0xBEEF1234, ready after 3 wait cycles:
  - BE=1100, requests held stable throughout.
  - o_rdData=0x0000BEEF at ready+1.
- SB addr 0x401, wrData 0x123456AB:
  - o_busWrEnable=1, BE=0010, o_busWrData=0xABABABAB.
  - No o_rdValid.
- LW addr 0x502:
  - No bus request.
  - o_misaligned=1 at cycle N+1 only, o_busy=1 at cycle N only.
- Load in ACCESS with i_busReady=0, i_reset pulled low mid-cycle:
  - All outputs 0 immediately.
  - After release: IDLE, a new request is accepted normally.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the memory-stage load/store unit: bus data word,
// access size encoding, FSM states and the byte-lane count.
package lsu_mem_port_pkg;

  typedef logic [31:0] Data;

  typedef enum logic [1:0] {
    ACCESS_BYTE = 2'd0,
    ACCESS_HALF = 2'd1,
    ACCESS_WORD = 2'd2
  } DataAccess;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } LsuState;

  localparam int BYTE_LANES = 4;

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Pure combinational lane logic: byte enables, store replication,
// load lane extraction with sign/zero extension, and the alignment check.
module lsu_lane_align
  import lsu_mem_port_pkg::*;
(
  input  DataAccess             i_access,
  input  logic [1:0]            i_addrLo,
  input  logic                  i_unsigned,
  input  Data                   i_wrData,
  input  Data                   i_busRdData,
  output logic [BYTE_LANES-1:0] o_byteEnable,
  output Data                   o_busWrData,
  output Data                   o_rdData,
  output logic                  o_misaligned
);

  Data lane;

  always_comb begin
    lane = i_busRdData >> {i_addrLo, 3'b000};
    case (i_access)
      ACCESS_BYTE: begin
        o_byteEnable = 4'b0001 << i_addrLo;
        o_busWrData  = {4{i_wrData[7:0]}};
        o_rdData     = i_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        o_misaligned = 1'b0;
      end
      ACCESS_HALF: begin
        o_byteEnable = 4'b0011 << {i_addrLo[1], 1'b0};
        o_busWrData  = {2{i_wrData[15:0]}};
        o_rdData     = i_unsigned ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        o_misaligned = i_addrLo[0];
      end
      // Word (and the unused encoding) ignores the unsigned flag.
      default: begin
        o_byteEnable = 4'b1111;
        o_busWrData  = i_wrData;
        o_rdData     = lane;
        o_misaligned = |i_addrLo;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory-stage load/store unit: runs each pipeline memory request as one
// word-bus transaction and stalls the pipeline until it completes.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_memRdEnable,
  input  logic                  i_memWrEnable,
  input  DataAccess             i_memAccess,
  input  logic                  i_memUnsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  Data                   i_wrData,
  output logic                  o_busy,
  output Data                   o_rdData,
  output logic                  o_rdValid,
  output logic                  o_misaligned,
  output logic [ADDR_WIDTH-1:0] o_busAddr,
  output logic                  o_busRdEnable,
  output logic                  o_busWrEnable,
  output logic [BYTE_LANES-1:0] o_busByteEnable,
  output Data                   o_busWrData,
  input  logic                  i_busReady,
  input  Data                   i_busRdData,
  output LsuState               o_state
);

  // Bus handshake: a request (rd or wr enable) is held stable with its
  // address/lanes/data until the cycle i_busReady=1, which completes it.

  LsuState               state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  DataAccess             access_q, access_d;
  logic                  unsigned_q, unsigned_d;
  Data                   wr_data_q, wr_data_d;
  logic                  store_q, store_d;
  Data                   rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  misaligned_q, misaligned_d;

  logic                  request;
  logic                  in_access;
  DataAccess             al_access;
  logic [1:0]            al_addr_lo;
  logic [BYTE_LANES-1:0] al_byte_enable;
  Data                   al_wr_data;
  Data                   al_rd_data;
  logic                  al_misaligned;

  assign request   = i_memRdEnable | i_memWrEnable;
  assign in_access = (state_q == ACCESS);

  // In IDLE only the alignment check matters, so it looks at the live request;
  // everywhere else the lane logic works from the captured request.
  assign al_access  = (state_q == IDLE) ? i_memAccess : access_q;
  assign al_addr_lo = (state_q == IDLE) ? i_addr[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .i_access     (al_access),
    .i_addrLo     (al_addr_lo),
    .i_unsigned   (unsigned_q),
    .i_wrData     (wr_data_q),
    .i_busRdData  (i_busRdData),
    .o_byteEnable (al_byte_enable),
    .o_busWrData  (al_wr_data),
    .o_rdData     (al_rd_data),
    .o_misaligned (al_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    access_d     = access_q;
    unsigned_d   = unsigned_q;
    wr_data_d    = wr_data_q;
    store_d      = store_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          addr_d       = i_addr;
          access_d     = i_memAccess;
          unsigned_d   = i_memUnsigned;
          wr_data_d    = i_wrData;
          store_d      = i_memWrEnable;
          misaligned_d = al_misaligned;
          state_d      = al_misaligned ? FAULT : ACCESS;
        end
      end
      ACCESS: begin
        if (i_busReady) begin
          if (!store_q) begin
            rd_data_d  = al_rd_data;
            rd_valid_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      // The old instruction is still presented in DONE/FAULT, so never re-accept it.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      access_q     <= ACCESS_BYTE;
      unsigned_q   <= 1'b0;
      wr_data_q    <= '0;
      store_q      <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      access_q     <= access_d;
      unsigned_q   <= unsigned_d;
      wr_data_q    <= wr_data_d;
      store_q      <= store_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Stall is combinational so a fresh request holds the pipeline in its first cycle.
  assign o_busy          = i_reset & (((state_q == IDLE) & request) | in_access);
  assign o_busAddr       = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign o_busRdEnable   = in_access & ~store_q;
  assign o_busWrEnable   = in_access & store_q;
  assign o_busByteEnable = in_access ? al_byte_enable : '0;
  assign o_busWrData     = in_access ? al_wr_data : '0;
  assign o_rdData        = rd_data_q;
  assign o_rdValid       = rd_valid_q;
  assign o_misaligned    = misaligned_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed load/store/fault/reset cases plus a
// randomized mix, with load results checked through an expected queue.
module tb_lsu_mem_port;
  import lsu_mem_port_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_memRdEnable = 1'b0;
  logic        i_memWrEnable = 1'b0;
  DataAccess   i_memAccess = ACCESS_BYTE;
  logic        i_memUnsigned = 1'b0;
  logic [31:0] i_addr = '0;
  Data         i_wrData = '0;
  logic        o_busy;
  Data         o_rdData;
  logic        o_rdValid;
  logic        o_misaligned;
  logic [31:0] o_busAddr;
  logic        o_busRdEnable;
  logic        o_busWrEnable;
  logic [3:0]  o_busByteEnable;
  Data         o_busWrData;
  logic        i_busReady = 1'b0;
  Data         i_busRdData = '0;
  LsuState     o_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  lsu_mem_port #(.ADDR_WIDTH(32)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_memRdEnable   (i_memRdEnable),
    .i_memWrEnable   (i_memWrEnable),
    .i_memAccess     (i_memAccess),
    .i_memUnsigned   (i_memUnsigned),
    .i_addr          (i_addr),
    .i_wrData        (i_wrData),
    .o_busy          (o_busy),
    .o_rdData        (o_rdData),
    .o_rdValid       (o_rdValid),
    .o_misaligned    (o_misaligned),
    .o_busAddr       (o_busAddr),
    .o_busRdEnable   (o_busRdEnable),
    .o_busWrEnable   (o_busWrEnable),
    .o_busByteEnable (o_busByteEnable),
    .o_busWrData     (o_busWrData),
    .i_busReady      (i_busReady),
    .i_busRdData     (i_busRdData),
    .o_state         (o_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic f_mis(input DataAccess acc, input logic [1:0] a);
    if (acc == ACCESS_HALF) return a[0];
    if (acc == ACCESS_WORD) return a != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_be(input DataAccess acc, input logic [1:0] a);
    case (acc)
      ACCESS_BYTE: case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
      ACCESS_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wd(input DataAccess acc, input logic [31:0] d);
    case (acc)
      ACCESS_BYTE: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      ACCESS_HALF: return {d[15:0], d[15:0]};
      default:     return d;
    endcase
  endfunction

  function automatic logic [31:0] f_ld(input DataAccess acc, input logic [1:0] a,
                                       input logic uns, input logic [31:0] bus);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = bus[7:0];
      2'd1: b = bus[15:8];
      2'd2: b = bus[23:16];
      default: b = bus[31:24];
    endcase
    h = a[1] ? bus[31:16] : bus[15:0];
    case (acc)
      ACCESS_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      ACCESS_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:     return bus;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    i_memRdEnable = 1'b0;
    i_memWrEnable = 1'b0;
    i_memAccess   = ACCESS_BYTE;
    i_memUnsigned = 1'b0;
    i_addr        = '0;
    i_wrData      = '0;
  endtask

  // Presents one request like the pipeline would (held until o_busy=0 is seen
  // at a clock edge) and checks every cycle of the transaction.
  task automatic run_op(input logic rd, input logic wr, input DataAccess acc, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] bus, input int waits);
    logic is_load;
    logic mis;
    is_load = rd & ~wr;
    mis     = f_mis(acc, addr[1:0]);
    @(posedge i_clock); #1;
    i_memRdEnable = rd;
    i_memWrEnable = wr;
    i_memAccess   = acc;
    i_memUnsigned = uns;
    i_addr        = addr;
    i_wrData      = wdata;
    i_busReady    = 1'b0;
    if (is_load && !mis) exp_q.push_back(f_ld(acc, addr[1:0], uns, bus));
    @(negedge i_clock);
    check("busy_req_cycle", o_busy, 1'b1);
    check("no_bus_req_cycle", {o_busRdEnable, o_busWrEnable}, 2'b00);
    if (mis) begin
      @(posedge i_clock); #1;
      @(negedge i_clock);
      check("fault_misaligned", o_misaligned, 1'b1);
      check("fault_busy", o_busy, 1'b0);
      check("fault_no_bus", {o_busRdEnable, o_busWrEnable}, 2'b00);
      check("fault_no_rdvalid", o_rdValid, 1'b0);
      @(posedge i_clock); #1;
      idle_inputs();
      @(negedge i_clock);
      check("misaligned_pulse_end", o_misaligned, 1'b0);
      check("fault_back_idle", o_state, IDLE);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        @(posedge i_clock); #1;
        i_busReady  = (w == waits);
        i_busRdData = (w == waits) ? bus : $urandom;
        @(negedge i_clock);
        check("access_busy", o_busy, 1'b1);
        check("bus_rd_en", o_busRdEnable, is_load);
        check("bus_wr_en", o_busWrEnable, wr);
        check("bus_addr", o_busAddr, {addr[31:2], 2'b00});
        check("bus_be", o_busByteEnable, f_be(acc, addr[1:0]));
        if (wr) check("bus_wdata", o_busWrData, f_wd(acc, wdata));
      end
      @(posedge i_clock); #1;
      i_busReady  = 1'b0;
      i_busRdData = $urandom;
      @(negedge i_clock);
      check("done_busy", o_busy, 1'b0);
      check("done_rdvalid", o_rdValid, is_load);
      check("done_no_bus", {o_busRdEnable, o_busWrEnable}, 2'b00);
      if (o_rdValid) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
        else check("rd_data", o_rdData, exp_q.pop_front());
      end else if (is_load && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
      @(posedge i_clock); #1;
      idle_inputs();
      @(negedge i_clock);
      check("rdvalid_pulse_end", o_rdValid, 1'b0);
      check("idle_busy", o_busy, 1'b0);
      check("back_idle", o_state, IDLE);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held;
    idle_inputs();
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_state", o_state, IDLE);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rdvalid", o_rdValid, 1'b0);
    check("rst_rddata", o_rdData, 32'h0);
    check("rst_bus_en", {o_busRdEnable, o_busWrEnable}, 2'b00);
    @(posedge i_clock); #1;
    i_reset = 1'b1;

    // LW aligned, ready in first access cycle
    run_op(1'b1, 1'b0, ACCESS_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_result", o_rdData, 32'hDEADBEEF);
    // LB / LBU from top lane
    run_op(1'b1, 1'b0, ACCESS_BYTE, 1'b0, 32'h203, 32'h0, 32'h80112233, 0);
    check("lb_result", o_rdData, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, ACCESS_BYTE, 1'b1, 32'h203, 32'h0, 32'h80112233, 0);
    check("lbu_result", o_rdData, 32'h00000080);
    // LHU upper half with 3 wait cycles
    run_op(1'b1, 1'b0, ACCESS_HALF, 1'b1, 32'h302, 32'h0, 32'hBEEF1234, 3);
    check("lhu_result", o_rdData, 32'h0000BEEF);
    // SB: replicated data, no load result, rdData holds
    held = o_rdData;
    run_op(1'b0, 1'b1, ACCESS_BYTE, 1'b0, 32'h401, 32'h123456AB, 32'h0, 1);
    check("sb_rd_hold", o_rdData, held);
    // Both enables: behaves as a store
    run_op(1'b1, 1'b1, ACCESS_WORD, 1'b0, 32'h600, 32'hCAFEF00D, 32'h11111111, 0);
    check("both_en_rd_hold", o_rdData, held);
    // Misaligned word and half, then a load right after
    run_op(1'b1, 1'b0, ACCESS_WORD, 1'b0, 32'h502, 32'h0, 32'h0, 0);
    run_op(1'b0, 1'b1, ACCESS_HALF, 1'b0, 32'h503, 32'h0, 32'h0, 0);
    run_op(1'b1, 1'b0, ACCESS_HALF, 1'b0, 32'h500, 32'h0, 32'h00008001, 2);
    check("lh_result", o_rdData, 32'hFFFF8001);

    // Reset in the middle of an outstanding load
    @(posedge i_clock); #1;
    i_memRdEnable = 1'b1;
    i_memAccess   = ACCESS_WORD;
    i_addr        = 32'h700;
    i_busReady    = 1'b0;
    @(posedge i_clock); #1;
    @(negedge i_clock);
    check("pre_rst_access", o_busRdEnable, 1'b1);
    #2 i_reset = 1'b0;
    #1;
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_bus_en", {o_busRdEnable, o_busWrEnable}, 2'b00);
    check("midrst_bus_addr", o_busAddr, 32'h0);
    check("midrst_be", o_busByteEnable, 4'h0);
    check("midrst_wdata", o_busWrData, 32'h0);
    check("midrst_rddata", o_rdData, 32'h0);
    check("midrst_flags", {o_rdValid, o_misaligned}, 2'b00);
    @(posedge i_clock); #1;
    idle_inputs();
    i_reset = 1'b1;
    @(negedge i_clock);
    check("post_rst_idle", o_state, IDLE);
    run_op(1'b1, 1'b0, ACCESS_BYTE, 1'b0, 32'h801, 32'h0, 32'h00007F00, 0);
    check("post_rst_lb", o_rdData, 32'h0000007F);

    // Randomized mix
    for (int n = 0; n < 24; n++) begin
      logic       r_wr;
      DataAccess  r_acc;
      logic [31:0] r_addr;
      r_wr   = 1'($urandom_range(0, 1));
      r_acc  = DataAccess'($urandom_range(0, 2));
      r_addr = {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3))};
      run_op(~r_wr, r_wr, r_acc, 1'($urandom_range(0, 1)), r_addr, $urandom, $urandom,
             $urandom_range(0, 3));
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
